multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the word-addressed CPU datapath. It walks each instruction through fetch, decode, execute, memory and writeback states, and handshakes with the shared instruction/data memory. It drives the writeback-select code (`mem_to_reg`), register-file write enable, ALU controls and PC update. Because the writeback mux registers its output, the controller presents `mem_to_reg` one cycle before `reg_write`. The PC stays stable for the whole instruction, so the mux's `pc+1` link value is correct for `jal`.

---
 rtl/ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// opcode-class bit positions and the datapath select codes.
package ctrl_pkg;

    // FSM state encoding, also exported on the debug state port
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC   = 4'd3;
    localparam logic [3:0] ST_MEM    = 4'd4;
    localparam logic [3:0] ST_WBSEL  = 4'd5;
    localparam logic [3:0] ST_WB     = 4'd6;
    localparam logic [3:0] ST_JUMP   = 4'd7;
    localparam logic [3:0] ST_ERROR  = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WBSEL  = ST_WBSEL,
        S_WB     = ST_WB,
        S_JUMP   = ST_JUMP,
        S_ERROR  = ST_ERROR
    } state_e;

    // Opcode field values
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Bit positions inside the one-hot opcode class vector
    localparam int CL_R    = 0;
    localparam int CL_LW   = 1;
    localparam int CL_SW   = 2;
    localparam int CL_BEQ  = 3;
    localparam int CL_J    = 4;
    localparam int CL_JAL  = 5;
    localparam int CL_ADDI = 6;
    localparam int CL_ILL  = 7;
    localparam int CL_W    = 8;

    // Writeback select
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC1 = 2'd2;

    // Destination register select
    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    // PC source select
    localparam logic [1:0] PCS_INC = 2'd0;
    localparam logic [1:0] PCS_BR  = 2'd1;
    localparam logic [1:0] PCS_JMP = 2'd2;

    // ALU operation
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: exactly one class bit is set for any
// opcode, with everything unrecognised landing in the ILLEGAL class.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0]  opcode_i,
    output logic [CL_W-1:0] cls_o
);

    // Map the opcode field onto its one-hot instruction class
    always_comb begin
        cls_o = {CL_W{1'b0}};
        case (opcode_i)
            OPW'(OP_R):    cls_o[CL_R]    = 1'b1;
            OPW'(OP_LW):   cls_o[CL_LW]   = 1'b1;
            OPW'(OP_SW):   cls_o[CL_SW]   = 1'b1;
            OPW'(OP_BEQ):  cls_o[CL_BEQ]  = 1'b1;
            OPW'(OP_J):    cls_o[CL_J]    = 1'b1;
            OPW'(OP_JAL):  cls_o[CL_JAL]  = 1'b1;
            OPW'(OP_ADDI): cls_o[CL_ADDI] = 1'b1;
            default:       cls_o[CL_ILL]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WBSEL/WB/JUMP and handshakes with the shared memory.
// Outputs are Moore-decoded from the state register and the opcode latched
// in DECODE; the only input-dependent outputs are the memory-completion
// strobes (ir_write, SW pc_write) and the BEQ branch select.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           ir_write,
    output logic           reg_write,
    output logic [1:0]     mem_to_reg,
    output logic [1:0]     reg_dst,
    output logic           alu_src,
    output logic [1:0]     alu_op,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           err,
    output logic [3:0]     state
);

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [OPW-1:0]  dec_op_s;
    logic [CL_W-1:0] cls_s;
    logic [1:0]      wb_m2r_s;
    logic [1:0]      wb_dst_s;

    // In DECODE the live IR field is classified; afterwards the latched copy
    // is, so a changing IR cannot disturb an instruction already in flight.
    assign dec_op_s = (state_q == S_DECODE) ? opcode : op_q;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode_i (dec_op_s),
        .cls_o    (cls_s)
    );

    assign state = state_q;

    // State register and latched opcode with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= {OPW{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Writeback select and destination, shared by WBSEL and WB so they match
    always_comb begin
        wb_m2r_s = M2R_ALU;
        wb_dst_s = RD_RT;
        if (cls_s[CL_R]) begin
            wb_m2r_s = M2R_ALU;
            wb_dst_s = RD_RD;
        end else if (cls_s[CL_LW]) begin
            wb_m2r_s = M2R_MEM;
            wb_dst_s = RD_RT;
        end else if (cls_s[CL_JAL]) begin
            wb_m2r_s = M2R_PC1;
            wb_dst_s = RD_R31;
        end else begin
            wb_m2r_s = M2R_ALU;
            wb_dst_s = RD_RT;
        end
    end

    // Next-state selection and Moore output decode
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = M2R_ALU;
        reg_dst    = RD_RT;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        pc_write   = 1'b0;
        pc_src     = PCS_INC;
        err        = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (cls_s[CL_R] | cls_s[CL_LW] | cls_s[CL_SW] |
                    cls_s[CL_BEQ] | cls_s[CL_ADDI]) begin
                    state_d = S_EXEC;
                end else if (cls_s[CL_J]) begin
                    state_d = S_JUMP;
                end else if (cls_s[CL_JAL]) begin
                    state_d = S_WBSEL;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC: begin
                if (cls_s[CL_R]) begin
                    alu_op  = ALU_FUNCT;
                    alu_src = 1'b0;
                    state_d = S_WBSEL;
                end else if (cls_s[CL_ADDI]) begin
                    alu_op  = ALU_ADD;
                    alu_src = 1'b1;
                    state_d = S_WBSEL;
                end else if (cls_s[CL_LW] | cls_s[CL_SW]) begin
                    alu_op  = ALU_ADD;
                    alu_src = 1'b1;
                    state_d = S_MEM;
                end else if (cls_s[CL_BEQ]) begin
                    alu_op   = ALU_SUB;
                    pc_write = 1'b1;
                    pc_src   = zero ? PCS_BR : PCS_INC;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = cls_s[CL_SW];
                if (mem_ready) begin
                    if (cls_s[CL_LW]) begin
                        state_d = S_WBSEL;
                    end else if (cls_s[CL_SW]) begin
                        pc_write = 1'b1;
                        pc_src   = PCS_INC;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WBSEL: begin
                mem_to_reg = wb_m2r_s;
                reg_dst    = wb_dst_s;
                state_d    = S_WB;
            end
            S_WB: begin
                mem_to_reg = wb_m2r_s;
                reg_dst    = wb_dst_s;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = cls_s[CL_JAL] ? PCS_JMP : PCS_INC;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCS_JMP;
                state_d  = S_FETCH;
            end
            S_ERROR: begin
                err     = 1'b1;
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction reference model
// expands each instruction (opcode, zero flag, fetch and memory wait counts)
// into the cycle-by-cycle output pattern it must produce; the runner drives
// inputs on the falling edge and compares every output shortly after.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic       we;
        logic       irw;
        logic       rw;
        logic [1:0] m2r;
        logic [1:0] rd;
        logic       asrc;
        logic [1:0] aop;
        logic       pcw;
        logic [1:0] pcs;
        logic       er;
    } ov_t;

    typedef struct packed {
        logic [5:0] op;
        logic       rdy;
        logic       zr;
        ov_t        e;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, ir_write, reg_write, alu_src, pc_write, err;
    logic [1:0] mem_to_reg, reg_dst, alu_op, pc_src;
    logic [3:0] state;
    ov_t        dut_v;

    cyc_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_ctrl #(.OPW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .err        (err),
        .state      (state)
    );

    assign dut_v = {state, mem_req, mem_we, ir_write, reg_write, mem_to_reg,
                    reg_dst, alu_src, alu_op, pc_write, pc_src, err};

    always #5 clk = ~clk;

    function automatic logic [5:0] rop();
        return 6'($urandom());
    endfunction

    function automatic logic rbit();
        return 1'($urandom());
    endfunction

    task automatic push(input logic [5:0] op, input logic rdy, input logic zr, input ov_t e);
        cyc_t c;
        c.op  = op;
        c.rdy = rdy;
        c.zr  = zr;
        c.e   = e;
        q.push_back(c);
    endtask

    // Reference model: expected cycles of one instruction
    task automatic build(input logic [5:0] op, input logic zr, input int fw, input int mw);
        ov_t e;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.st = S_FETCH; e.req = 1'b1;
            push(rop(), 1'b0, rbit(), e);
        end
        e = '0; e.st = S_FETCH; e.req = 1'b1; e.irw = 1'b1;
        push(rop(), 1'b1, rbit(), e);
        e = '0; e.st = S_DECODE;
        push(op, rbit(), rbit(), e);
        case (op)
            T_R, T_ADDI: begin
                e = '0; e.st = S_EXEC;
                e.aop  = (op == T_R) ? 2'd2 : 2'd0;
                e.asrc = (op == T_R) ? 1'b0 : 1'b1;
                push(rop(), rbit(), rbit(), e);
                e = '0; e.st = S_WBSEL; e.m2r = 2'd0;
                e.rd = (op == T_R) ? 2'd1 : 2'd0;
                push(rop(), rbit(), rbit(), e);
                e.st = S_WB; e.rw = 1'b1; e.pcw = 1'b1; e.pcs = 2'd0;
                push(rop(), rbit(), rbit(), e);
            end
            T_LW, T_SW: begin
                e = '0; e.st = S_EXEC; e.aop = 2'd0; e.asrc = 1'b1;
                push(rop(), rbit(), rbit(), e);
                for (int i = 0; i < mw; i++) begin
                    e = '0; e.st = S_MEM; e.req = 1'b1; e.we = (op == T_SW);
                    push(rop(), 1'b0, rbit(), e);
                end
                e = '0; e.st = S_MEM; e.req = 1'b1; e.we = (op == T_SW);
                if (op == T_SW) begin
                    e.pcw = 1'b1; e.pcs = 2'd0;
                end
                push(rop(), 1'b1, rbit(), e);
                if (op == T_LW) begin
                    e = '0; e.st = S_WBSEL; e.m2r = 2'd1; e.rd = 2'd0;
                    push(rop(), rbit(), rbit(), e);
                    e.st = S_WB; e.rw = 1'b1; e.pcw = 1'b1; e.pcs = 2'd0;
                    push(rop(), rbit(), rbit(), e);
                end
            end
            T_BEQ: begin
                e = '0; e.st = S_EXEC; e.aop = 2'd1; e.pcw = 1'b1;
                e.pcs = zr ? 2'd1 : 2'd0;
                push(rop(), rbit(), zr, e);
            end
            T_J: begin
                e = '0; e.st = S_JUMP; e.pcw = 1'b1; e.pcs = 2'd2;
                push(rop(), rbit(), rbit(), e);
            end
            T_JAL: begin
                e = '0; e.st = S_WBSEL; e.m2r = 2'd2; e.rd = 2'd2;
                push(rop(), rbit(), rbit(), e);
                e.st = S_WB; e.rw = 1'b1; e.pcw = 1'b1; e.pcs = 2'd2;
                push(rop(), rbit(), rbit(), e);
            end
            default: begin
                for (int i = 0; i < 12; i++) begin
                    e = '0; e.st = S_ERROR; e.er = 1'b1;
                    push(rop(), rbit(), rbit(), e);
                end
            end
        endcase
    endtask

    // Play queued cycles (at most limit of them) and compare each one
    task automatic run(input string name, input int limit);
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            c = q.pop_front();
            @(negedge clk);
            opcode = c.op; mem_ready = c.rdy; zero = c.zr;
            #1;
            n_checks++;
            if (dut_v !== c.e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, n, dut_v, c.e);
            end
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0; zero = rbit(); opcode = rop();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        ov_t e;
        @(negedge clk);
        rst = 1'b1; mem_ready = rbit(); zero = rbit(); opcode = rop();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = rbit(); zero = rbit(); opcode = rop();
            #1;
            n_checks++;
            if (dut_v !== ov_t'(0)) begin
                n_fail++;
                $display("FAIL reset_hold %0d: got %h expected 0", i, dut_v);
            end
        end
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        n_checks++;
        if (dut_v !== ov_t'(0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0", dut_v);
        end
        @(negedge clk);
        #1;
        e = '0; e.st = S_FETCH; e.req = 1'b1;
        n_checks++;
        if (dut_v !== e) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got %h expected %h", dut_v, e);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        build(T_R, 1'b0, 0, 0);
        build(T_ADDI, 1'b0, 0, 0);
        run("rtype_addi", 1000);
    endtask

    task automatic test_lw_wait();
        do_reset();
        build(T_LW, 1'b0, 1, 3);
        run("lw_wait", 1000);
    endtask

    task automatic test_beq();
        do_reset();
        build(T_BEQ, 1'b1, 0, 0);
        build(T_BEQ, 1'b0, 0, 0);
        run("beq", 1000);
    endtask

    task automatic test_jal();
        do_reset();
        build(T_JAL, 1'b0, 0, 0);
        build(T_J, 1'b0, 0, 0);
        run("jal_j", 1000);
    endtask

    task automatic test_illegal();
        do_reset();
        build(T_BAD, 1'b0, 0, 0);
        run("illegal", 1000);
    endtask

    task automatic test_reset_mid_sw();
        do_reset();
        build(T_SW, 1'b0, 0, 5);
        // FETCH, DECODE, EXEC and three waiting MEM cycles
        run("sw_pre_reset", 6);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (dut_v !== ov_t'(0)) begin
            n_fail++;
            $display("FAIL sw_mid_reset: got %h expected 0", dut_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7];
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_JAL, T_ADDI};
        do_reset();
        for (int i = 0; i < 30; i++) begin
            build(ops[$urandom_range(0, 6)], rbit(), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)));
        end
        build(T_BAD, 1'b0, 0, 0);
        run("back_to_back", 100000);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_jal();
        test_illegal();
        test_reset_mid_sw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
